// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the two ALU clients and the arbiter
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0][3:0]       req_op;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_slt;
  logic                  rsp_ult;
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_slt, rsp_ult
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_slt, rsp_ult
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one transaction in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_slt,
  input  logic             alu_ult,
  output logic             busy,
  output logic             owner
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             owner_q, owner_d, zero_q, zero_d, slt_q, slt_d, ult_q, ult_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d, grant;
  logic             win;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win = ~bus.req_valid[0];
`else
  logic last_q, last_d;
  assign win = &bus.req_valid ? ~last_q : bus.req_valid[1];
`endif
  assign grant          = (rst_n && state_q == IDLE && |bus.req_valid) ? (2'b01 << win) : 2'b00;
  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_slt    = slt_q;
  assign bus.rsp_ult    = ult_q;
  assign alu_src_a      = a_q;
  assign alu_src_b      = b_q;
  assign alu_ctrl       = ctrl_q;
  assign owner          = owner_q;
  assign busy           = state_q != IDLE;
  // next-state: accept winner in IDLE, capture ALU outputs in EXEC, wait for handshake in RESP
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    owner_d     = owner_q;
    res_d       = res_q;
    zero_d      = zero_q;
    slt_d       = slt_q;
    ult_d       = ult_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    if (|grant) begin
      a_d     = bus.req_a[win];
      b_d     = bus.req_b[win];
      ctrl_d  = bus.req_op[win];
      owner_d = win;
      state_d = EXEC;
    end else if (state_q == EXEC) begin
      res_d       = alu_result;
      zero_d      = alu_zero;
      slt_d       = alu_slt;
      ult_d       = alu_ult;
      rsp_valid_d = 2'b01 << owner_q;
      state_d     = RESP;
    end else if (state_q == RESP && bus.rsp_ready[owner_q]) begin
      rsp_valid_d = 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_d      = owner_q;
`endif
      state_d     = IDLE;
    end
  end
  // state and registered outputs; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      owner_q     <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      slt_q       <= 1'b0;
      ult_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      owner_q     <= owner_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      slt_q       <= slt_d;
      ult_q       <= ult_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a behavioural ALU
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_slt, alu_ult, busy, owner;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_res [2];
  logic        exp_slt [2];
  logic        o;
  alu_arbiter_if #(.WIDTH(32)) bus ();
  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_slt(alu_slt), .alu_ult(alu_ult),
    .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  // behavioural ALU
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src_a + alu_src_b;
      4'b0001: alu_result = alu_src_a - alu_src_b;
      4'b0010: alu_result = alu_src_a & alu_src_b;
      4'b0011: alu_result = alu_src_a | alu_src_b;
      4'b0100: alu_result = alu_src_a ^ alu_src_b;
      4'b0101: alu_result = alu_src_a << alu_src_b[4:0];
      4'b0110: alu_result = alu_src_a >> alu_src_b[4:0];
      4'b0111: alu_result = {31'h0, $signed(alu_src_a) < $signed(alu_src_b)};
      4'b1000: alu_result = {31'h0, alu_src_a < alu_src_b};
      4'b1001: alu_result = alu_src_b;
      4'b1010: alu_result = $signed(alu_src_a) >>> alu_src_b[4:0];
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_ctrl == 4'b0001) && (alu_result == 32'h0);
    alu_slt  = $signed(alu_src_a) < $signed(alu_src_b);
    alu_ult  = alu_src_a < alu_src_b;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rsp(input string tag, input logic [1:0] v, input logic [31:0] r,
                         input logic z, input logic s, input logic u);
    chk({tag, "_valid"}, bus.rsp_valid, v);
    chk({tag, "_result"}, bus.rsp_result, r);
    chk({tag, "_zero"}, bus.rsp_zero, z);
    chk({tag, "_slt"}, bus.rsp_slt, s);
    chk({tag, "_ult"}, bus.rsp_ult, u);
  endtask
  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    #1;
    chk_rsp("reset", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset_ready", bus.req_ready, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_owner", owner, 1'b0);
    chk("reset_src", {alu_src_a, alu_src_b}, 64'h0);
    chk("reset_ctrl", alu_ctrl, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    // single request from requester 0: 5 - 3
    bus.rsp_ready = 2'b11;
    bus.req_a[0] = 32'd5;
    bus.req_b[0] = 32'd3;
    bus.req_op[0] = 4'b0001;
    bus.req_valid = 2'b01;
    #1;
    chk("single_ready", bus.req_ready, 2'b01);
    step();
    bus.req_valid = 2'b00;
    chk("single_busy_exec", busy, 1'b1);
    chk("single_src", {alu_src_a, alu_src_b}, {32'd5, 32'd3});
    chk("single_ctrl", alu_ctrl, 4'b0001);
    chk("single_exec_ready", bus.req_ready, 2'b00);
    chk("single_exec_valid", bus.rsp_valid, 2'b00);
    step();
    chk("single_busy_resp", busy, 1'b1);
    chk_rsp("single", 2'b01, 32'd2, 1'b0, 1'b0, 1'b0);
    step();
    chk("single_busy_idle", busy, 1'b0);
    chk("single_valid_clr", bus.rsp_valid, 2'b00);
    // zero flag from requester 1: 7 - 7, then 7 + 7
    bus.req_a[1] = 32'd7;
    bus.req_b[1] = 32'd7;
    bus.req_op[1] = 4'b0001;
    bus.req_valid = 2'b10;
    #1;
    chk("zero_ready", bus.req_ready, 2'b10);
    step();
    bus.req_valid = 2'b00;
    chk("zero_owner", owner, 1'b1);
    step();
    chk_rsp("zero_sub", 2'b10, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    bus.req_op[1] = 4'b0000;
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = 2'b00;
    step();
    chk_rsp("zero_add", 2'b10, 32'd14, 1'b0, 1'b0, 1'b0);
    step();
    // tie: both valid continuously
    bus.req_a[0] = 32'h0000F0F0;
    bus.req_b[0] = 32'h00000FF0;
    bus.req_op[0] = 4'b0010;
    bus.req_a[1] = 32'h80000000;
    bus.req_b[1] = 32'd4;
    bus.req_op[1] = 4'b1010;
    exp_res[0] = 32'h000000F0;
    exp_slt[0] = 1'b0;
    exp_res[1] = 32'hF8000000;
    exp_slt[1] = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      o = FIXED ? 1'b0 : i[0];
      chk("tie_ready", bus.req_ready, 2'b01 << o);
      step();
      chk("tie_owner", owner, o);
      step();
      chk_rsp("tie", 2'b01 << o, exp_res[o], 1'b0, exp_slt[o], 1'b0);
      step();
    end
    // backpressure on requester 0 while requester 1 waits
    bus.rsp_ready = 2'b10;
    chk("bp_ready", bus.req_ready, 2'b01);
    step();
    step();
    chk_rsp("bp_first", 2'b01, 32'h000000F0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", bus.rsp_valid, 2'b01);
      chk("bp_hold_result", bus.rsp_result, 32'h000000F0);
      chk("bp_hold_ready", bus.req_ready, 2'b00);
      chk("bp_hold_busy", busy, 1'b1);
    end
    bus.rsp_ready = 2'b11;
    #1;
    chk("bp_no_comb_ready", bus.req_ready, 2'b00);
    step();
    chk("bp_after_valid", bus.rsp_valid, 2'b00);
    chk("bp_after_ready", bus.req_ready, FIXED ? 2'b01 : 2'b10);
    step();
    chk("bp_after_owner", owner, FIXED ? 1'b0 : 1'b1);
    chk("bp_after_busy", busy, 1'b1);
    // reset asserted in EXEC
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk_rsp("rst_mid", 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_owner", owner, 1'b0);
    chk("rst_mid_src", {alu_src_a, alu_src_b}, 64'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_rsp", bus.rsp_valid, 2'b00);
      chk("rst_idle", busy, 1'b0);
    end
    bus.req_valid = 2'b11;
    #1;
    chk("rst_tie_ready", bus.req_ready, 2'b01);
    step();
    chk("rst_tie_owner", owner, 1'b0);
    bus.req_valid = 2'b00;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single combinational ALU between the execute stage (requester 0) and a secondary client such as a branch/address helper (requester 1). Each request carries operands and a 4-bit ALU control code. The block registers the winning request onto the ALU inputs, captures the result and comparison flags one cycle later, and returns them on a per-requester valid/ready response channel. Only one transaction is in flight at a time.

## Interface
- `WIDTH`, 32: operand/result width; must match the ALU.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, bit i = requester i.
- `req_ready` out 2: request accepted this cycle (one-hot or zero).
- `req_a` in 2×WIDTH: operand A per requester.
- `req_b` in 2×WIDTH: operand B per requester.
- `req_op` in 2×4: ALU control per requester.
- `rsp_valid` out 2: response valid (one-hot or zero).
- `rsp_ready` in 2: requester consumes the response.
- `rsp_result` out WIDTH: captured ALU result, shared by both requesters.
- `rsp_zero`, `rsp_slt`, `rsp_ult` out 1 each: captured Zero, signed-less and unsigned-less flags.
- `alu_src_a`, `alu_src_b` out WIDTH: registered ALU operands.
- `alu_ctrl` out 4: registered ALU control.
- `alu_result` in WIDTH; `alu_zero`, `alu_slt`, `alu_ult` in 1: ALU outputs.
- `busy` out 1: high in EXEC or RESP.
- `owner` out 1: index of the requester currently owning the ALU.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If no `req_valid` is set, stay in IDLE.
  - Otherwise select a winner. Under round-robin, the requester that was not granted last wins a tie.
  - `req_ready[winner]` = 1, driven combinationally from `req_valid` and the priority pointer.
  - On the clock edge: load `req_a`/`req_b`/`req_op` of the winner into `alu_src_a`/`alu_src_b`/`alu_ctrl`, set `owner`, and go to EXEC.
- EXEC
  - Capture `alu_result`, `alu_zero`, `alu_slt` and `alu_ult` into the rsp registers.
  - Set `rsp_valid[owner]` and go to RESP.
- RESP
  - Hold the rsp registers and the ALU input registers stable.
  - When `rsp_valid[owner]` && `rsp_ready[owner]`: clear `rsp_valid`, set the priority pointer to "last granted = owner", and go to IDLE.
- `req_op` is passed through unmodified. Codes 1011–1111 produce the ALU default (result 0); the arbiter does not flag them.
- `rsp_zero` reflects the ALU Zero as produced: 1 only for op 0001 (SUB) with equal operands. `rsp_slt` and `rsp_ult` are valid for every op.
- Requesters hold `req_valid` and the payload stable until accepted. Dropping `req_valid` early is a protocol violation; the arbiter does not check for it.
- `req_ready` is 0 in EXEC and RESP regardless of `req_valid`.
- Reset values:
  - State IDLE.
  - `req_ready`, `rsp_valid` = 0.
  - `rsp_result`, `rsp_*` flags, `alu_src_a`, `alu_src_b`, `alu_ctrl` = 0.
  - `owner` = 0; `busy` = 0.
  - Priority pointer = "last granted = 1", so requester 0 wins the first tie.
- Reset asserted mid-transaction: the in-flight operation is dropped silently and no response is issued. Requesters must reissue.

## Timing
- Accept at edge N (`req_ready` high in cycle N-1 → edge N).
- `rsp_valid` is high from edge N+1 onward.
- Minimum request-to-request spacing per arbiter: 3 cycles (IDLE, EXEC, RESP with `rsp_ready` already high).
- `rsp_ready` held low stalls in RESP indefinitely. No new request is accepted during the stall.
- Simultaneous requests: exactly one is granted. The loser stays pending and, if still valid, is granted in the next IDLE.
- `req_ready` has a combinational path from `req_valid`. No combinational path exists from `rsp_ready` to `req_ready`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority; requester 0 always wins ties. The priority pointer is removed, and requester 1 can starve.
- Not defined (default): round-robin as described above.

## Test plan
- Single request: requester 0 sends a=5, b=3, op=0001 → `rsp_valid[0]` at edge N+1 with result 2, zero 0, slt 0, ult 0; `busy` high for 2 cycles.
- Zero flag: requester 1 sends a=7, b=7, op=0001 → result 0, zero 1. The same operands with op=0000 → result 14, zero 0.
- Tie, round-robin: both valid continuously with `rsp_ready` high → grants alternate 0,1,0,1. Results carry the correct owner (requester 0 op 0010 0xF0F0&0x0FF0 = 0x00F0; requester 1 op 1010 0x80000000>>>4 = 0xF8000000).
- Backpressure: hold `rsp_ready[0]` low for 5 cycles → `rsp_valid[0]` and `rsp_result` stable, `req_ready` = 0 even with `req_valid[1]` = 1; requester 1 is granted the cycle after the handshake.
- Reset mid-op: assert `rst_n` low in EXEC → all outputs 0 immediately, no response after release, and the first tie then goes to requester 0.
- With `ALU_ARB_FIXED_PRIO_EN`: both valid continuously → requester 0 granted every time, `req_ready[1]` never asserted.
